// File: rtl/mac_col_drain.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mac_col_drain                                                |
// | Description : Result-unload controller for one systolic MAC column. Shifts |
// |               the accumulated C values down the chain one per cycle,       |
// |               captures the bottom PE's Cout and presents it on a           |
// |               valid/ready stream. The column is left cleared, or reloaded  |
// |               from pre_data when DRAIN_PRELOAD_EN is defined.              |
// | Options     : DRAIN_PRELOAD_EN - adds pre_data/pre_idx so the column is    |
// |               refilled with initial C values while it drains.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mac_col_drain #(
  parameter int BITS_C = 16,
  parameter int DIM    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      col_en,
  output logic                      col_wren,
  output logic [BITS_C-1:0]         col_cin,
  input  logic [BITS_C-1:0]         col_cout,
`ifdef DRAIN_PRELOAD_EN
  input  logic [BITS_C-1:0]         pre_data,
  output logic [$clog2(DIM)-1:0]    pre_idx,
`endif
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic signed [BITS_C-1:0]  res_data,
  output logic [$clog2(DIM)-1:0]    res_idx,
  output logic                      res_last
);

  localparam int IW = $clog2(DIM);
  localparam logic [IW-1:0] c_LAST_IDX = IW'(DIM - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LAST  = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [IW-1:0]              r_count;
  logic                       w_fire;
  logic                       w_busy;
  logic                       r_res_valid;
  logic signed [BITS_C-1:0]   r_res_data;
  logic [IW-1:0]              r_res_idx;
  logic                       r_res_last;
  logic [BITS_C-1:0]          w_cin_src;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and shift-fire decode; a shift only fires when the output
  // register is empty or being emptied this cycle, so no beat is overwritten
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_fire      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_busy = 1'b1;
        w_fire = !r_res_valid || res_ready;
        if (w_fire && (r_count == c_LAST_IDX)) begin
          w_state_nxt = S_LAST;
        end
      end
      S_LAST: begin
        w_busy = 1'b1;
        if (res_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef DRAIN_PRELOAD_EN
  assign w_cin_src = pre_data;
  assign pre_idx   = r_count;
`else
  assign w_cin_src = '0;
`endif

  assign busy     = w_busy;
  assign col_en   = w_fire;
  assign col_wren = w_fire;
  assign col_cin  = w_fire ? w_cin_src : '0;

  // Beat counter: cleared on start, advanced once per shift
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_count <= '0;
    end else if (w_fire) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Result register: captures the pre-edge bottom Cout on every shift and
  // holds it stable under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_idx   <= '0;
      r_res_last  <= 1'b0;
    end else if (w_fire) begin
      r_res_valid <= 1'b1;
      r_res_data  <= col_cout;
      r_res_idx   <= r_count;
      r_res_last  <= (r_count == c_LAST_IDX);
    end else if ((r_state == S_LAST) && res_ready) begin
      r_res_valid <= 1'b0;
      r_res_last  <= 1'b0;
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_idx   = r_res_idx;
  assign res_last  = r_res_last;

endmodule
`default_nettype wire

// File: tb/tb_mac_col_drain.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mac_col_drain                                             |
// | Description : Self-checking bench for mac_col_drain with a behavioural     |
// |               column of PEs and a queue of expected beats.                 |
// | Options     : DRAIN_PRELOAD_EN enables the preload scenario.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mac_col_drain;

  localparam int DIM    = 4;
  localparam int BITS_C = 16;
  localparam int IW     = $clog2(DIM);

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic                     busy;
  logic                     col_en;
  logic                     col_wren;
  logic [BITS_C-1:0]        col_cin;
  logic [BITS_C-1:0]        col_cout;
  logic                     res_valid;
  logic                     res_ready;
  logic signed [BITS_C-1:0] res_data;
  logic [IW-1:0]            res_idx;
  logic                     res_last;
`ifdef DRAIN_PRELOAD_EN
  logic [BITS_C-1:0]        pre_data;
  logic [IW-1:0]            pre_idx;
`endif

  // Column model: index 0 is the bottom PE, DIM-1 the top PE
  logic [BITS_C-1:0] col     [DIM];
  logic [BITS_C-1:0] ld_vals [DIM];
  logic              ld;
  logic [BITS_C-1:0] pre_tab [DIM];
  logic [BITS_C-1:0] exp_q   [$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mac_col_drain #(.BITS_C(BITS_C), .DIM(DIM)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .col_en    (col_en),
    .col_wren  (col_wren),
    .col_cin   (col_cin),
    .col_cout  (col_cout),
`ifdef DRAIN_PRELOAD_EN
    .pre_data  (pre_data),
    .pre_idx   (pre_idx),
`endif
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_idx   (res_idx),
    .res_last  (res_last)
  );

`ifdef DRAIN_PRELOAD_EN
  assign pre_data = pre_tab[pre_idx];
`endif

  assign col_cout = col[0];

  // PE chain: shift down when enabled with write select; direct load for setup
  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < DIM; i++) col[i] <= ld_vals[i];
    end else if (col_en && col_wren) begin
      for (int i = 0; i < DIM - 1; i++) col[i] <= col[i+1];
      col[DIM-1] <= col_cin;
    end
  end

  task automatic load4(input int a, input int b, input int c, input int d);
    ld_vals[0] = BITS_C'(a);
    ld_vals[1] = BITS_C'(b);
    ld_vals[2] = BITS_C'(c);
    ld_vals[3] = BITS_C'(d);
    @(negedge clk);
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic expect4(input int a, input int b, input int c, input int d);
    exp_q.delete();
    exp_q.push_back(BITS_C'(a));
    exp_q.push_back(BITS_C'(b));
    exp_q.push_back(BITS_C'(c));
    exp_q.push_back(BITS_C'(d));
  endtask

  // One complete unload. mode 0: ready high, 1: random ready,
  // 2: ready low for 3 cycles once the first beat appears.
  task automatic run_drain(input string name, input int mode, input int repulse_c,
                           input bit start_at_last);
    int c, en_cycles, busy_cycles, beats, first_v, stall_left;
    c = 0; en_cycles = 0; busy_cycles = 0; beats = 0; first_v = 0; stall_left = 3;
    @(negedge clk);
    start = 1'b1;
    res_ready = 1'b1;
    while (c < 200) begin
      @(negedge clk);
      c++;
      case (mode)
        1: res_ready = 1'($urandom_range(0, 1));
        2: if (res_valid && beats == 0 && stall_left > 0) begin
             res_ready = 1'b0;
             stall_left--;
           end else res_ready = 1'b1;
        default: res_ready = 1'b1;
      endcase
      start = (c == repulse_c) || (start_at_last && res_valid && res_last && res_ready);
      #1;
      if (c == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL %s busy_after_start: got %b want 1", name, busy);
        end
        checks++;
        if (res_valid !== 1'b0) begin
          errors++; $display("FAIL %s valid_latency: got %b want 0", name, res_valid);
        end
      end
      if (!busy) begin
        checks++;
        if (res_valid !== 1'b0) begin
          errors++; $display("FAIL %s valid_idle: got %b want 0", name, res_valid);
        end
        break;
      end
      busy_cycles++;
      checks++;
      if (col_wren !== col_en) begin
        errors++; $display("FAIL %s wren: got %b want %b", name, col_wren, col_en);
      end
      if (res_valid && !res_ready) begin
        checks++;
        if (col_en !== 1'b0) begin
          errors++; $display("FAIL %s freeze: col_en got %b want 0", name, col_en);
        end
      end
      if (col_en) begin
        checks++;
        if (en_cycles >= DIM) begin
          errors++; $display("FAIL %s extra_shift: got %0d want <%0d", name, en_cycles + 1, DIM);
        end else if (col_cin !== pre_tab[en_cycles]) begin
          errors++; $display("FAIL %s cin: got %0d want %0d", name, col_cin, pre_tab[en_cycles]);
        end
        en_cycles++;
      end
      if (res_valid) begin
        if (first_v == 0) first_v = c;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL %s extra_beat: got idx %0d want none", name, res_idx);
        end else begin
          if (res_data !== exp_q[0]) begin
            errors++;
            $display("FAIL %s data: got %0d want %0d", name, res_data, $signed(exp_q[0]));
          end
          checks++;
          if (res_idx !== IW'(beats)) begin
            errors++; $display("FAIL %s idx: got %0d want %0d", name, res_idx, beats);
          end
          checks++;
          if (res_last !== (beats == DIM - 1)) begin
            errors++; $display("FAIL %s last: got %b want %b", name, res_last, beats == DIM - 1);
          end
        end
        if (res_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          beats++;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (c >= 200) begin
      errors++; $display("FAIL %s timeout: got %0d cycles want <200", name, c);
    end
    checks++;
    if (beats != DIM) begin
      errors++; $display("FAIL %s beats: got %0d want %0d", name, beats, DIM);
    end
    checks++;
    if (en_cycles != DIM) begin
      errors++; $display("FAIL %s shifts: got %0d want %0d", name, en_cycles, DIM);
    end
    if (mode == 0) begin
      checks++;
      if (busy_cycles != DIM + 1) begin
        errors++; $display("FAIL %s busy_len: got %0d want %0d", name, busy_cycles, DIM + 1);
      end
      checks++;
      if (first_v != 2) begin
        errors++; $display("FAIL %s first_beat: got %0d want 2", name, first_v);
      end
    end
    for (int j = 0; j < DIM; j++) begin
      checks++;
      if (col[j] !== pre_tab[j]) begin
        errors++; $display("FAIL %s column[%0d]: got %0d want %0d", name, j, col[j], pre_tab[j]);
      end
    end
    if (start_at_last) begin
      @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL %s start_on_accept: busy got %b want 0", name, busy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; res_ready = 1'b1; ld = 1'b0;
    for (int i = 0; i < DIM; i++) pre_tab[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({busy, res_valid, res_last, col_en, col_wren} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000", {busy, res_valid, res_last, col_en, col_wren});
    end
    checks++;
    if (res_data !== '0 || res_idx !== '0 || col_cin !== '0) begin
      errors++;
      $display("FAIL reset_data: got %0d/%0d/%0d want 0/0/0", res_data, res_idx, col_cin);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    load4(5, -3, 100, 32767);
    expect4(5, -3, 100, 32767);
    run_drain("basic", 0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    load4(5, -3, 100, 32767);
    expect4(5, -3, 100, 32767);
    run_drain("stall", 2, 0, 1'b0);
  endtask

  task automatic test_start_ignored();
    load4(5, -3, 100, 32767);
    expect4(5, -3, 100, 32767);
    run_drain("restart", 0, 3, 1'b1);
    expect4(0, 0, 0, 0);
    run_drain("cleared", 0, 0, 1'b0);
  endtask

  task automatic test_async_reset();
    load4(5, -3, 100, 32767);
    @(negedge clk);
    start = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (res_valid !== 1'b1 || res_data !== 16'sd5) begin
      errors++; $display("FAIL rst_beat1: got %b/%0d want 1/5", res_valid, res_data);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, res_valid, res_last, col_en} !== 4'b0 || res_data !== '0 || res_idx !== '0) begin
      errors++;
      $display("FAIL async_reset: got %b data %0d idx %0d want 0000 0 0",
               {busy, res_valid, res_last, col_en}, res_data, res_idx);
    end
    @(negedge clk);
    rst = 1'b0;
    expect4(-3, 100, 32767, 0);
    run_drain("after_rst", 0, 0, 1'b0);
  endtask

  task automatic test_extremes();
    load4(-32768, 32767, -32768, 32767);
    expect4(-32768, 32767, -32768, 32767);
    run_drain("extremes", 1, 0, 1'b0);
  endtask

  task automatic test_random();
    int v[4];
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 4; i++) v[i] = int'($urandom_range(0, 65535)) - 32768;
      load4(v[0], v[1], v[2], v[3]);
      expect4(v[0], v[1], v[2], v[3]);
      run_drain("random", 1, 0, 1'b0);
    end
  endtask

`ifdef DRAIN_PRELOAD_EN
  task automatic test_preload();
    load4(7, 8, 9, 11);
    expect4(7, 8, 9, 11);
    pre_tab[0] = 16'd10; pre_tab[1] = 16'd20; pre_tab[2] = 16'd30; pre_tab[3] = 16'd40;
    run_drain("preload", 0, 0, 1'b0);
    expect4(10, 20, 30, 40);
    for (int i = 0; i < DIM; i++) pre_tab[i] = '0;
    run_drain("preload_out", 1, 0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_start_ignored();
    test_async_reset();
    test_extremes();
    test_random();
`ifdef DRAIN_PRELOAD_EN
    test_preload();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
